// File: rtl/sync_updown_modcounter_if.sv
// Control/status bundle of the up/down modulo counter.
// Signal direction prefixes are from the counter's point of view.
interface sync_updown_modcounter_if #(
   parameter int NBITS = 4
);
   logic             i_clr;
   logic             i_load;
   logic [NBITS-1:0] i_load_val;
   logic             i_ena;
   logic             i_up_dn;
   logic [NBITS-1:0] o_counter;
   logic             o_tc_out;
   logic             o_ovf;

   modport master (
      output i_clr, i_load, i_load_val, i_ena, i_up_dn,
      input  o_counter, o_tc_out, o_ovf
   );

   modport slave (
      input  i_clr, i_load, i_load_val, i_ena, i_up_dn,
      output o_counter, o_tc_out, o_ovf
   );
endinterface

// File: rtl/sync_updown_modcounter.sv
// Up/down counter modulo MODULUS with clear, clamped load, wrap/saturate mode,
// sticky boundary-event flag and a zero-latency cascade enable (tc_out).
module sync_updown_modcounter #(
   parameter int NBITS    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   sync_updown_modcounter_if.slave  bus
);

   if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << NBITS))) begin : g_bad_modulus
      $fatal(1, "sync_updown_modcounter: MODULUS %0d out of range for NBITS %0d", MODULUS, NBITS);
   end

   localparam logic [NBITS-1:0] LP_MAX     = NBITS'(MODULUS - 1);
   localparam logic [NBITS:0]   LP_MOD_EXT = (NBITS+1)'(MODULUS);

   logic [NBITS-1:0] r_counter;
   logic             r_ovf;

   logic             w_at_max;
   logic             w_at_zero;
   logic [NBITS-1:0] w_load_clamped;
   logic [NBITS-1:0] w_next_cnt;
   logic             w_next_ovf;
   logic             w_tc;

   assign w_at_max  = (r_counter == LP_MAX);
   assign w_at_zero = (r_counter == {NBITS{1'b0}});

   // Clamp out-of-range load values to the top of the count range.
   always_comb begin
      w_load_clamped = bus.i_load_val;
      if ({1'b0, bus.i_load_val} >= LP_MOD_EXT) begin
         w_load_clamped = LP_MAX;
      end else begin
         w_load_clamped = bus.i_load_val;
      end
   end

   // Next-state selection: clr > load > ena > hold.
   always_comb begin
      w_next_cnt = r_counter;
      w_next_ovf = r_ovf;
      if (bus.i_clr) begin
         w_next_cnt = {NBITS{1'b0}};
         w_next_ovf = 1'b0;
      end else if (bus.i_load) begin
         w_next_cnt = w_load_clamped;
      end else if (bus.i_ena) begin
         if (bus.i_up_dn) begin
            if (w_at_max) begin
               w_next_ovf = 1'b1;
               if (SATURATE != 0) begin
                  w_next_cnt = r_counter;
               end else begin
                  w_next_cnt = {NBITS{1'b0}};
               end
            end else begin
               w_next_cnt = r_counter + {{(NBITS-1){1'b0}}, 1'b1};
            end
         end else begin
            if (w_at_zero) begin
               w_next_ovf = 1'b1;
               if (SATURATE != 0) begin
                  w_next_cnt = r_counter;
               end else begin
                  w_next_cnt = LP_MAX;
               end
            end else begin
               w_next_cnt = r_counter - {{(NBITS-1){1'b0}}, 1'b1};
            end
         end
      end else begin
         w_next_cnt = r_counter;
         w_next_ovf = r_ovf;
      end
   end

   // Count and sticky flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_counter <= {NBITS{1'b0}};
         r_ovf     <= 1'b0;
      end else begin
         r_counter <= w_next_cnt;
         r_ovf     <= w_next_ovf;
      end
   end

   // tc_out ignores clr/load so a downstream stage still sees the intended step.
   assign w_tc = ~rst & bus.i_ena &
                 ((bus.i_up_dn & w_at_max) | (~bus.i_up_dn & w_at_zero));

   assign bus.o_counter = r_counter;
   assign bus.o_ovf     = r_ovf;
   assign bus.o_tc_out  = w_tc;

endmodule

// File: tb/tb_sync_updown_modcounter.sv
// Directed bench: wrap and saturate counters (MODULUS=10) plus a two-stage decade cascade.
module tb_sync_updown_modcounter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sync_updown_modcounter_if #(.NBITS(4)) if_w  ();
   sync_updown_modcounter_if #(.NBITS(4)) if_s  ();
   sync_updown_modcounter_if #(.NBITS(4)) if_c0 ();
   sync_updown_modcounter_if #(.NBITS(4)) if_c1 ();

   sync_updown_modcounter #(.NBITS(4), .MODULUS(10), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(if_w));
   sync_updown_modcounter #(.NBITS(4), .MODULUS(10), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .bus(if_s));
   sync_updown_modcounter #(.NBITS(4), .MODULUS(10), .SATURATE(0)) u_c0   (.clk(clk), .rst(rst), .bus(if_c0));
   sync_updown_modcounter #(.NBITS(4), .MODULUS(10), .SATURATE(0)) u_c1   (.clk(clk), .rst(rst), .bus(if_c1));

   assign if_c1.i_ena = if_c0.o_tc_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      if_w.i_clr = 1'b0;  if_w.i_load = 1'b0;  if_w.i_load_val = 4'd0;  if_w.i_ena = 1'b1;  if_w.i_up_dn = 1'b0;
      if_s.i_clr = 1'b0;  if_s.i_load = 1'b0;  if_s.i_load_val = 4'd0;  if_s.i_ena = 1'b0;  if_s.i_up_dn = 1'b1;
      if_c0.i_clr = 1'b0; if_c0.i_load = 1'b0; if_c0.i_load_val = 4'd0; if_c0.i_ena = 1'b0; if_c0.i_up_dn = 1'b1;
      if_c1.i_clr = 1'b0; if_c1.i_load = 1'b0; if_c1.i_load_val = 4'd0;                     if_c1.i_up_dn = 1'b1;

      // reset state: held across an edge, tc forced low even with a down boundary present
      #1;
      chk("rst_cnt", 32'(if_w.o_counter), 32'd0);
      chk("rst_ovf", 32'(if_w.o_ovf), 32'd0);
      chk("rst_tc", 32'(if_w.o_tc_out), 32'd0);
      tick();
      chk("rst_hold_cnt", 32'(if_w.o_counter), 32'd0);
      if_w.i_up_dn = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // 1: count up 12 cycles, wrap 9 -> 0
      for (int i = 1; i <= 12; i++) begin
         #1;
         chk("t1_tc", 32'(if_w.o_tc_out), (((i - 1) % 10) == 9) ? 32'd1 : 32'd0);
         tick();
         chk("t1_cnt", 32'(if_w.o_counter), 32'(i % 10));
         chk("t1_ovf", 32'(if_w.o_ovf), (i >= 10) ? 32'd1 : 32'd0);
      end

      // 2: clear, then count down 0 -> 9 -> 8 -> 7
      if_w.i_ena = 1'b0;
      if_w.i_clr = 1'b1;
      tick();
      chk("t2_clr_cnt", 32'(if_w.o_counter), 32'd0);
      chk("t2_clr_ovf", 32'(if_w.o_ovf), 32'd0);
      if_w.i_clr = 1'b0;
      if_w.i_ena = 1'b1;
      if_w.i_up_dn = 1'b0;
      #1;
      chk("t2_tc0", 32'(if_w.o_tc_out), 32'd1);
      tick();
      chk("t2_cnt9", 32'(if_w.o_counter), 32'd9);
      chk("t2_ovf", 32'(if_w.o_ovf), 32'd1);
      chk("t2_tc9", 32'(if_w.o_tc_out), 32'd0);
      tick();
      chk("t2_cnt8", 32'(if_w.o_counter), 32'd8);
      tick();
      chk("t2_cnt7", 32'(if_w.o_counter), 32'd7);
      chk("t2_ovf_sticky", 32'(if_w.o_ovf), 32'd1);
      if_w.i_ena = 1'b0;

      // 3: saturate mode
      if_s.i_load = 1'b1;
      if_s.i_load_val = 4'd8;
      tick();
      chk("t3_load8", 32'(if_s.o_counter), 32'd8);
      chk("t3_ovf0", 32'(if_s.o_ovf), 32'd0);
      if_s.i_load = 1'b0;
      if_s.i_ena = 1'b1;
      tick();
      chk("t3_cnt9", 32'(if_s.o_counter), 32'd9);
      chk("t3_ovf_pre", 32'(if_s.o_ovf), 32'd0);
      chk("t3_tc", 32'(if_s.o_tc_out), 32'd1);
      tick();
      chk("t3_hold1", 32'(if_s.o_counter), 32'd9);
      chk("t3_ovf_set", 32'(if_s.o_ovf), 32'd1);
      tick();
      chk("t3_hold2", 32'(if_s.o_counter), 32'd9);
      tick();
      chk("t3_hold3", 32'(if_s.o_counter), 32'd9);
      if_s.i_up_dn = 1'b0;
      tick();
      chk("t3_down8", 32'(if_s.o_counter), 32'd8);
      chk("t3_ovf_keep", 32'(if_s.o_ovf), 32'd1);
      if_s.i_ena = 1'b0;
      tick();
      chk("t3_idle_hold", 32'(if_s.o_counter), 32'd8);

      // 4: priority clr > load > ena, and load clamping
      if_w.i_load_val = 4'd13;
      if_w.i_load = 1'b1;
      if_w.i_clr = 1'b1;
      if_w.i_ena = 1'b1;
      tick();
      chk("t4_prio_cnt", 32'(if_w.o_counter), 32'd0);
      chk("t4_prio_ovf", 32'(if_w.o_ovf), 32'd0);
      if_w.i_clr = 1'b0;
      if_w.i_ena = 1'b0;
      tick();
      chk("t4_clamp13", 32'(if_w.o_counter), 32'd9);
      chk("t4_ovf_unch", 32'(if_w.o_ovf), 32'd0);
      if_w.i_load_val = 4'd3;
      if_w.i_ena = 1'b1;
      tick();
      chk("t4_load_over_ena", 32'(if_w.o_counter), 32'd3);
      if_w.i_load_val = 4'd10;
      tick();
      chk("t4_clamp10", 32'(if_w.o_counter), 32'd9);
      if_w.i_load = 1'b0;
      if_w.i_ena = 1'b0;

      // 5: two-stage decade cascade 00..99 then 00
      if_c0.i_clr = 1'b1;
      if_c1.i_clr = 1'b1;
      tick();
      if_c0.i_clr = 1'b0;
      if_c1.i_clr = 1'b0;
      if_c0.i_ena = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         #1;
         chk("t5_tc1", 32'(if_c1.o_tc_out), ((k - 1) == 99) ? 32'd1 : 32'd0);
         tick();
         chk("t5_ones", 32'(if_c0.o_counter), 32'(k % 10));
         chk("t5_tens", 32'(if_c1.o_counter), 32'((k % 100) / 10));
      end
      chk("t5_ovf1", 32'(if_c1.o_ovf), 32'd1);
      if_c0.i_ena = 1'b0;

      // 6: async reset mid-cycle at count 5 (wrap instance at 9, ovf 0)
      if_w.i_ena = 1'b1;
      if_w.i_up_dn = 1'b1;
      tick();
      chk("t6_wrap0", 32'(if_w.o_counter), 32'd0);
      chk("t6_ovf_set", 32'(if_w.o_ovf), 32'd1);
      for (int j = 1; j <= 5; j++) begin
         tick();
      end
      chk("t6_cnt5", 32'(if_w.o_counter), 32'd5);
      #1;
      rst = 1'b1;
      if_w.i_up_dn = 1'b0;
      #1;
      chk("t6_async_cnt", 32'(if_w.o_counter), 32'd0);
      chk("t6_async_ovf", 32'(if_w.o_ovf), 32'd0);
      chk("t6_async_tc", 32'(if_w.o_tc_out), 32'd0);
      chk("t6_async_sat_ovf", 32'(if_s.o_ovf), 32'd0);
      if_w.i_up_dn = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_rel_cnt", 32'(if_w.o_counter), 32'd0);
      tick();
      chk("t6_resume", 32'(if_w.o_counter), 32'd1);
      chk("t6_resume_ovf", 32'(if_w.o_ovf), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
